// File: rtl/su_adder_for_ambi_irrel.sv
// su_adder_for_ambi_irrel: sums groups of irrel_num PE psum lanes into rel_num packed results per RF entry
//   clk, reset (async, active-low)
//   psum_out        : all PE psums of the RF entry at psum_rf_addr, lane i at [DATA_BITWIDTH*i +: DATA_BITWIDTH]
//   pe_psum_finish  : rising edge starts a pass over every RF entry
//   conv_finish     : rewinds the GBF write pointer and toggles the buffer (deferred to IDLE)
//   irrel_num       : lanes per group, rel_num: number of groups; both latched at pass start
//   psum_rf_addr    : RF entry being read
//   out_data, psum_gbf_w_en, psum_gbf_w_addr, psum_gbf_w_num : registered GBF write port
//   su_add_finish   : pulses with the last write of a pass
module su_adder_for_ambi_irrel #(
   parameter int ROW                   = 16,
   parameter int COL                   = 16,
   parameter int DATA_BITWIDTH         = 16,
   parameter int GBF_DATA_BITWIDTH     = 512,
   parameter int PSUM_RF_ADDR_BITWIDTH = 2,
   parameter int DEPTH                 = 32
)(
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [DATA_BITWIDTH*ROW*COL-1:0]      psum_out,
   input  logic                                  pe_psum_finish,
   input  logic                                  conv_finish,
   input  logic [4:0]                            irrel_num,
   input  logic [4:0]                            rel_num,
   output logic [PSUM_RF_ADDR_BITWIDTH-1:0]      psum_rf_addr,
   output logic                                  su_add_finish,
   output logic [GBF_DATA_BITWIDTH-1:0]          out_data,
   output logic                                  psum_gbf_w_en,
   output logic [4:0]                            psum_gbf_w_addr,
   output logic                                  psum_gbf_w_num
);
   localparam int DW    = DATA_BITWIDTH;
   localparam int LANES = ROW * COL;
   localparam int SLOTS = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
   localparam int MAXG  = 16;
   localparam logic [4:0] WLAST = 5'(DEPTH - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t                       r_state;
   logic                         r_prev;
   logic                         r_conv_pend;
   logic [4:0]                   r_irrel;
   logic [4:0]                   r_rel;
   logic [4:0]                   r_wptr;
   logic [GBF_DATA_BITWIDTH-1:0] w_data;
   logic                         w_start;
   logic                         w_last;
   assign w_start = pe_psum_finish & ~r_prev;
   assign w_last  = psum_rf_addr == '1;
   // Groups are laid out back to back from lane 0; lanes past the last group or the array are ignored.
   always_comb begin
      w_data = '0;
      for (int g = 0; g < SLOTS; g++)
         for (int j = 0; j < MAXG; j++)
            w_data[g*DW +: DW] = w_data[g*DW +: DW] +
               ((g < int'(r_rel) && j < int'(r_irrel) && g*int'(r_irrel) + j < LANES)
                  ? psum_out[DW*(g*int'(r_irrel) + j) +: DW] : {DW{1'b0}});
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= IDLE;
         r_prev          <= 1'b0;
         r_conv_pend     <= 1'b0;
         r_irrel         <= '0;
         r_rel           <= '0;
         r_wptr          <= '0;
         psum_rf_addr    <= '0;
         su_add_finish   <= 1'b0;
         out_data        <= '0;
         psum_gbf_w_en   <= 1'b0;
         psum_gbf_w_addr <= '0;
         psum_gbf_w_num  <= 1'b0;
      end else begin
         r_prev        <= pe_psum_finish;
         psum_gbf_w_en <= 1'b0;
         su_add_finish <= 1'b0;
         if (r_state == IDLE) begin
            if (w_start) begin
               r_state <= RUN;
               r_irrel <= irrel_num;
               r_rel   <= rel_num;
            end
            // A conv_finish seen during the pass is applied here so that pass kept its buffer.
            if (conv_finish || r_conv_pend) begin
               r_wptr         <= '0;
               psum_gbf_w_num <= ~psum_gbf_w_num;
               r_conv_pend    <= 1'b0;
            end
         end else begin
            out_data        <= w_data;
            psum_gbf_w_en   <= 1'b1;
            psum_gbf_w_addr <= r_wptr;
            r_wptr          <= (r_wptr == WLAST) ? '0 : r_wptr + 1'b1;
            psum_rf_addr    <= psum_rf_addr + 1'b1;
            if (conv_finish) r_conv_pend <= 1'b1;
            if (w_last) begin
               su_add_finish <= 1'b1;
               r_state       <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_su_adder_for_ambi_irrel.sv
// tb_su_adder_for_ambi_irrel: directed and random passes checked against an arithmetic group-sum model
module tb_su_adder_for_ambi_irrel;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [4095:0] psum_out;
   logic          pe_psum_finish = 1'b0;
   logic          conv_finish = 1'b0;
   logic [4:0]    irrel_num = '0;
   logic [4:0]    rel_num = '0;
   logic [1:0]    psum_rf_addr;
   logic          su_add_finish;
   logic [511:0]  out_data;
   logic          psum_gbf_w_en;
   logic [4:0]    psum_gbf_w_addr;
   logic          psum_gbf_w_num;
   logic [4095:0] rf [4];
   int            n_assert = 0;
   int            n_fail = 0;
   int            exp_wptr = 0;
   logic          exp_num = 1'b0;
   su_adder_for_ambi_irrel dut (
      .clk(clk), .reset(reset), .psum_out(psum_out), .pe_psum_finish(pe_psum_finish),
      .conv_finish(conv_finish), .irrel_num(irrel_num), .rel_num(rel_num),
      .psum_rf_addr(psum_rf_addr), .su_add_finish(su_add_finish), .out_data(out_data),
      .psum_gbf_w_en(psum_gbf_w_en), .psum_gbf_w_addr(psum_gbf_w_addr), .psum_gbf_w_num(psum_gbf_w_num)
   );
   assign psum_out = rf[psum_rf_addr];
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [511:0] model(input logic [4095:0] d, input int irr, input int rel);
      logic [511:0] w = '0;
      for (int g = 0; g < 32; g++) begin
         int s = 0;
         if (g < rel)
            for (int j = 0; j < irr; j++)
               if (g*irr + j < 256) s += int'(d[(g*irr + j)*16 +: 16]);
         w[g*16 +: 16] = 16'(s % 65536);
      end
      return w;
   endfunction
   task automatic fill_rows(input int kind);
      for (int e = 0; e < 4; e++)
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
               rf[e][(r*16 + c)*16 +: 16] = (kind == 0) ? ((c < 7) ? 16'd0 : 16'd1)
                                          : (kind == 1) ? ((c < r % 8) ? 16'd0 : 16'd1)
                                          : (kind == 2) ? 16'hFFFF : 16'($urandom);
   endtask
   task automatic run_pass(input int irr, input int rel, input bit conv_mid);
      int  lat = 0;
      bit  seen = 0;
      @(negedge clk);
      pe_psum_finish = 1'b0;
      irrel_num = 5'(irr);
      rel_num = 5'(rel);
      @(negedge clk);
      pe_psum_finish = 1'b1;
      while (!seen && lat < 12) begin
         @(negedge clk);
         lat++;
         seen = psum_gbf_w_en;
         conv_finish = conv_mid && lat == 1;
      end
      conv_finish = 1'b0;
      chk("first_write_latency", 512'(lat), 512'(2));
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("w_en[%0d]", k), 512'(psum_gbf_w_en), 512'(1));
         chk($sformatf("w_addr[%0d]", k), 512'(psum_gbf_w_addr), 512'(exp_wptr));
         chk($sformatf("w_num[%0d]", k), 512'(psum_gbf_w_num), 512'(exp_num));
         chk($sformatf("finish[%0d]", k), 512'(su_add_finish), 512'(k == 3));
         chk($sformatf("data[%0d] irr=%0d rel=%0d", k, irr, rel), out_data, model(rf[k], irr, rel));
         exp_wptr = (exp_wptr + 1) % 32;
      end
      @(negedge clk);
      chk("w_en_after_pass", 512'(psum_gbf_w_en), 512'(0));
      chk("finish_after_pass", 512'(su_add_finish), 512'(0));
      chk("rf_addr_idle", 512'(psum_rf_addr), 512'(0));
      if (conv_mid) begin
         exp_wptr = 0;
         exp_num = ~exp_num;
      end
   endtask
   initial begin
      int irr;
      int rel;
      fill_rows(3);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_w_en", 512'(psum_gbf_w_en), 512'(0));
      chk("rst_rf_addr", 512'(psum_rf_addr), 512'(0));
      chk("rst_out_data", out_data, 512'(0));
      chk("rst_misc", {su_add_finish, psum_gbf_w_addr, psum_gbf_w_num}, 512'(0));
      reset = 1'b1;
      fill_rows(0);
      run_pass(2, 6, 0);
      chk("p0_slot3", 512'(out_data[3*16 +: 16]), 512'(1));
      chk("p0_slot5", 512'(out_data[5*16 +: 16]), 512'(2));
      chk("p0_slot6", 512'(out_data[6*16 +: 16]), 512'(0));
      fill_rows(1);
      run_pass(16, 16, 0);
      chk("p1_slot0", 512'(out_data[0 +: 16]), 512'(16));
      chk("p1_slot7", 512'(out_data[7*16 +: 16]), 512'(9));
      chk("p1_slot8", 512'(out_data[8*16 +: 16]), 512'(16));
      @(negedge clk);
      conv_finish = 1'b1;
      @(negedge clk);
      conv_finish = 1'b0;
      exp_wptr = 0;
      exp_num = ~exp_num;
      fill_rows(3);
      run_pass(3, 9, 0);
      fill_rows(3);
      run_pass(5, 20, 1);
      run_pass(7, 31, 0);
      fill_rows(2);
      run_pass(1, 31, 0);
      chk("wrap1_slot0", 512'(out_data[0 +: 16]), 512'(16'hFFFF));
      chk("wrap1_slot31", 512'(out_data[31*16 +: 16]), 512'(0));
      run_pass(16, 16, 0);
      chk("wrap16_slot15", 512'(out_data[15*16 +: 16]), 512'(16'hFFF0));
      run_pass(4, 0, 0);
      chk("rel0_zero", out_data, 512'(0));
      for (int p = 0; p < 8; p++) begin
         fill_rows(3);
         irr = int'($urandom_range(1, 16));
         rel = int'($urandom_range(1, (256 / irr > 31) ? 31 : 256 / irr));
         run_pass(irr, rel, 0);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("held_high_no_w_en", 512'(psum_gbf_w_en), 512'(0));
      end
      @(negedge clk);
      pe_psum_finish = 1'b0;
      @(negedge clk);
      pe_psum_finish = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_pass_w_en", 512'(psum_gbf_w_en), 512'(1));
      #1 reset = 1'b0;
      #1;
      chk("abort_w_en", 512'(psum_gbf_w_en), 512'(0));
      chk("abort_out_data", out_data, 512'(0));
      chk("abort_regs", {psum_rf_addr, su_add_finish, psum_gbf_w_addr, psum_gbf_w_num}, 512'(0));
      @(negedge clk);
      reset = 1'b1;
      pe_psum_finish = 1'b0;
      exp_wptr = 0;
      exp_num = 1'b0;
      fill_rows(3);
      run_pass(8, 32 - 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
